// File: rtl/tetris_display_pkg.sv
// rtl/tetris_display_pkg.sv - shared segment patterns and digit-array type for the score display
package tetris_display_pkg;

  typedef logic [3:0] digit_arr_t [0:3];

  // Active-low cathodes ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  function automatic logic [3:0] slot_anode_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to active-low seven-segment decode
module bcd_to_seg
  import tetris_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - multiplexed 4-digit score display with game-over blink; LEADING_ZERO_BLANK_EN enables leading-zero blanking
module score_display
  import tetris_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  digit_arr_t digits,
  input  logic       gameState,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  digit_arr_t    shadow;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          tick;
  logic          lz_blank;
  logic          blank;
  logic [6:0]    seg_next;

  assign tick = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign dp   = 1'b1;

  bcd_to_seg u_dec (
    .bcd (shadow[idx]),
    .seg (seg_next)
  );

  // A digit is a leading zero when it and every more significant digit are zero
  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    lz_blank = (shadow[3] == 4'd0);
      2'd2:    lz_blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
      2'd1:    lz_blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0) && (shadow[1] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`endif
  end

  // gameState is used directly so returning to play un-blanks on the very next edge
  assign blank = (~gameState & blink_phase) | lz_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '{default: 4'd0};
      refresh_cnt <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= 4'hF;
      seg         <= SEG_OFF;
    end else begin
      if (load) begin
        shadow <= digits;
      end

      if (tick) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end

      if (gameState) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      an  <= blank ? 4'hF : slot_anode_n(idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard bench for score_display against a cycle-count reference model
module tb_score_display;
  import tetris_display_pkg::*;

  localparam int R = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       gameState = 1'b1;
  digit_arr_t digits;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  score_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digits    (digits),
    .gameState (gameState),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  // Model state: edges since reset, refresh ticks seen during game over, shown digits
  int n = 0;
  int blink_ticks = 0;
  int sh[4] = '{0, 0, 0, 0};

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   slot;
    bit   off;
    if (reset) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      n = 0;
      blink_ticks = 0;
      for (int k = 0; k < 4; k++) sh[k] = 0;
    end else begin
      slot = (n / R) % 4;
      off  = !gameState && (((blink_ticks / B) % 2) == 1);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0) begin
        bit allz;
        allz = 1'b1;
        for (int k = slot; k < 4; k++) if (sh[k] != 0) allz = 1'b0;
        if (allz) off = 1'b1;
      end
`endif
      for (int k = 0; k < 4; k++) e.an[k] = off || (k != slot);
      e.seg = seg_of(sh[slot]);
      e.dp  = 1'b1;
      if (gameState) blink_ticks = 0;
      else if ((n % R) == R - 1) blink_ticks++;
      if (load) for (int k = 0; k < 4; k++) sh[k] = int'(digits[k]);
      n++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if ({an, seg, dp} !== e) begin
        mismatched++;
        $display("FAIL scoreboard t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    digits = '{4'd9, 4'd9, 4'd9, 4'd9};
    load   = 1'b1;
    step(3);
    load = 1'b0;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1);
    reset = 1'b0;
    step(1);
    check("release_an", an, 4'hE);
    check("load_in_reset_discarded", seg, 7'h40);

    digits = '{4'd4, 4'd3, 4'd2, 4'd1};
    load   = 1'b1;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      case (an)
        4'hE: check("scan_slot0", seg, 7'h19);
        4'hD: check("scan_slot1", seg, 7'h30);
        4'hB: check("scan_slot2", seg, 7'h24);
        4'h7: check("scan_slot3", seg, 7'h79);
        default: check("scan_one_hot", an, 4'hE);
      endcase
    end

    digits = '{4'd4, 4'd3, 4'hC, 4'd1};
    load   = 1'b1;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (an == 4'hB) check("dash_slot2", seg, 7'h3F);
    end

    gameState = 1'b0;
    step(40);
    gameState = 1'b1;
    step(1);
    check("resume_scan", $countones(an), 3);
    step(10);

    for (int i = 0; i < R; i++) begin
      if ((n % R) == R - 1) break;
      step(1);
    end
    digits = '{4'd7, 4'd6, 4'd5, 4'd8};
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(20);

    step(5);
    reset = 1'b1;
    step(1);
    check("midscan_reset_an", an, 4'hF);
    check("midscan_reset_seg", seg, 7'h7F);
    reset = 1'b0;
    step(1);
    check("midscan_restart_an", an, 4'hE);

    digits = '{4'd5, 4'd0, 4'd0, 4'd0};
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(20);
    digits = '{4'd0, 4'd0, 4'd0, 4'd0};
    load   = 1'b1;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (an == 4'hE) check("zero_slot0", seg, 7'h40);
    end

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) == 0);
      load  = ($urandom_range(5) == 0);
      for (int k = 0; k < 4; k++)
        digits[k] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
      if ($urandom_range(39) == 0) gameState = ~gameState;
      step(1);
    end
    reset = 1'b0;
    load  = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (1 kHz per slot at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 250, giving refresh ticks per blink phase (2 Hz blink at defaults).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port load, input, 1 bit, single-cycle strobe that captures digits.
REQ-006 SHALL have port digits, input, 4x4-bit unpacked array [0:3], BCD score digits with index 0 as least significant.
REQ-007 SHALL have port gameState, input, 1 bit, 1 = playing and 0 = game over.
REQ-008 SHALL have port an, output, 4 bits, active-low anode select with bit i driving digit i.
REQ-009 SHALL have port seg, output, 7 bits, active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port dp, output, 1 bit, decimal point, held 1 (off).

Function
REQ-011 SHALL latch digits into a shadow register on any clk edge with load=1; displayed digits SHALL change only on load (no tearing).
REQ-012 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps to 0; a refresh tick is the cycle in which the count equals REFRESH_DIV-1.
REQ-013 SHALL advance a 2-bit slot index 0->1->2->3->0 on each refresh tick.
REQ-014 SHALL register an and seg from the slot index and shadow value, with a latency of exactly one cycle after an index or shadow change.
REQ-015 SHALL drive exactly one an bit low per cycle (an = ~(1<<index)) unless the slot is blanked.
REQ-016 SHALL decode BCD 0-9 to standard patterns (0=7'h40, 1=7'h79, 8=7'h00, 9=7'h10); values 10-15 SHALL show a dash (7'h3F).
REQ-017 SHALL count refresh ticks in a blink counter while gameState=0 and toggle blink_phase every BLINK_DIV ticks.
REQ-018 SHALL, when gameState=0 and blink_phase=1, force an=4'hF while the refresh counter and slot index keep running.
REQ-019 SHALL, when gameState=1, clear the blink counter and blink_phase in the same cycle.
REQ-020 SHALL, when load and a refresh tick coincide, use the new shadow value for the newly selected slot.

Reset
REQ-021 SHALL, on reset, set an=4'hF, seg=7'h7F, dp=1, shadow=0, slot index=0, refresh count=0, blink count=0, blink_phase=0.
REQ-022 SHALL have reset take priority over load; a load strobe coincident with reset SHALL be discarded.
REQ-023 SHALL, on reset asserted mid-scan, return outputs to reset values on the next edge and restart the scan at slot 0.

Configuration
REQ-024 SHALL, with LEADING_ZERO_BLANK_EN defined, blank digit i (i=3,2,1) by holding its an bit high when that digit and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-025 SHALL, without LEADING_ZERO_BLANK_EN, display all four digits, including leading zeros.

Structure
REQ-026 SHALL place the segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and the 4x4-bit BCD digit array typedef in the shared package tetris_display_pkg.
REQ-027 SHALL implement BCD-to-segment decode in the combinational sub-module bcd_to_seg, instantiated once.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-028 SHALL verify: reset asserted -> an=4'hF, seg=7'h7F, dp=1 on the next edge; after release, slot 0 is selected (an=4'hE) one cycle later.
REQ-029 SHALL verify: load digits={4,3,2,1} with gameState=1 -> slots cycle every 4 clks with an E,D,B,7 and seg SEG_4,SEG_3,SEG_2,SEG_1.
REQ-030 SHALL verify: digits[2]=4'hC loaded -> seg=7'h3F while an=4'hB.
REQ-031 SHALL verify: gameState=0 -> an alternates between scanning for 8 clks and 4'hF for 8 clks; setting gameState=1 resumes scanning immediately.
REQ-032 SHALL verify: with LEADING_ZERO_BLANK_EN and digits={5,0,0,0} -> only slot 0 lights; with digits={0,0,0,0} -> slot 0 shows SEG_0.
REQ-033 SHALL verify: load coincident with reset -> shadow remains 0; load coincident with a refresh tick -> the new digit is shown in the new slot.
